// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core, one instruction retired per clock.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   rom_in   - instruction word at rom_addr (combinational ROM)
//   rom_addr - word address of the current instruction (PC[31:2])
//   ram_in   - aligned data word containing ram_addr (combinational read)
//   ram_addr - byte address for loads/stores (rs1 + imm), 0 otherwise
//   ram_out  - store data replicated into byte lanes
//   ram_r    - high while a load executes
//   ram_w    - per-byte-lane write enable, RAM writes on the rising edge
//   brk      - sticky halt flag, set when EBREAK retires
module rv32i_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rom_in,
    output logic [29:0] rom_addr,
    input  logic [31:0] ram_in,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_out,
    output logic        ram_r,
    output logic [3:0]  ram_w,
    output logic        brk
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;

    logic [31:0] pc_q, pc_d;
    logic        brk_q, brk_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, eff_addr, op_b, alu_res, ld_data;
    logic        alt, taken, rd_we, is_load, is_store;
    logic [31:0] rd_wdata, st_data;
    logic [3:0]  st_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign opcode = rom_in[6:0];
    assign rd     = rom_in[11:7];
    assign funct3 = rom_in[14:12];
    assign rs1    = rom_in[19:15];
    assign rs2    = rom_in[24:20];

    assign imm_i = {{20{rom_in[31]}}, rom_in[31:20]};
    assign imm_s = {{20{rom_in[31]}}, rom_in[31:25], rom_in[11:7]};
    assign imm_b = {{19{rom_in[31]}}, rom_in[31], rom_in[7], rom_in[30:25], rom_in[11:8], 1'b0};
    assign imm_u = {rom_in[31:12], 12'h000};
    assign imm_j = {{11{rom_in[31]}}, rom_in[31], rom_in[19:12], rom_in[20], rom_in[30:21], 1'b0};

    // x0 is never written and resets to 0, so a plain array read is enough.
    assign rs1_val = rf_q[rs1];
    assign rs2_val = rf_q[rs2];

    assign is_load  = (opcode == OpLoad);
    assign is_store = (opcode == OpStore);
    // Shared by loads, stores and JALR.
    assign eff_addr = rs1_val + (is_store ? imm_s : imm_i);

    // ALU: the funct7 bit only selects SUB/SRA for register ops and for SRAI.
    assign op_b = (opcode == OpReg) ? rs2_val : imm_i;
    assign alt  = rom_in[30] && ((opcode == OpReg) || (funct3 == 3'b101));

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alt ? rs1_val - op_b : rs1_val + op_b;
            3'b001: alu_res = rs1_val << op_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011: alu_res = {31'b0, rs1_val < op_b};
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: alu_res = alt ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
            3'b110: alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: taken = !($signed(rs1_val) < $signed(rs2_val));
            3'b110: taken = (rs1_val < rs2_val);
            3'b111: taken = !(rs1_val < rs2_val);
            default: taken = 1'b0;
        endcase
    end

    // Load lane extraction; misaligned halfword/word accesses are not fixed up.
    always_comb begin
        ld_byte = ram_in[7:0];
        case (eff_addr[1:0])
            2'b00: ld_byte = ram_in[7:0];
            2'b01: ld_byte = ram_in[15:8];
            2'b10: ld_byte = ram_in[23:16];
            default: ld_byte = ram_in[31:24];
        endcase
        ld_half = eff_addr[1] ? ram_in[31:16] : ram_in[15:0];
        case (funct3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_data = {24'b0, ld_byte};
            3'b101: ld_data = {16'b0, ld_half};
            default: ld_data = ram_in;
        endcase
    end

    always_comb begin
        pc_d     = pc_q + 32'd4;
        brk_d    = brk_q;
        rd_we    = 1'b0;
        rd_wdata = '0;
        st_data  = '0;
        st_mask  = 4'b0000;
        case (opcode)
            OpLui: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OpAuipc: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OpJal: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = pc_q + imm_j;
            end
            OpJalr: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = eff_addr & ~32'd1;
            end
            OpBranch: begin
                if (taken) pc_d = pc_q + imm_b;
            end
            OpLoad: begin
                rd_we    = 1'b1;
                rd_wdata = ld_data;
            end
            OpStore: begin
                case (funct3)
                    3'b000: begin
                        st_data = {4{rs2_val[7:0]}};
                        st_mask = 4'b0001 << eff_addr[1:0];
                    end
                    3'b001: begin
                        st_data = {2{rs2_val[15:0]}};
                        st_mask = 4'b0011 << {eff_addr[1], 1'b0};
                    end
                    3'b010: begin
                        st_data = rs2_val;
                        st_mask = 4'b1111;
                    end
                    default: ;
                endcase
            end
            OpImm, OpReg: begin
                rd_we    = 1'b1;
                rd_wdata = alu_res;
            end
            default: begin
                // EBREAK parks the PC on itself; other SYSTEM/FENCE/unknown are NOPs.
                if (rom_in == InstEbreak) begin
                    brk_d = 1'b1;
                    pc_d  = pc_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            brk_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (!brk_q) begin
            pc_q  <= pc_d & 32'hFFFF_FFFC;
            brk_q <= brk_d;
            if (rd_we && (rd != 5'd0)) rf_q[rd] <= rd_wdata;
        end
    end

    assign rom_addr = pc_q[31:2];
    assign ram_addr = (is_load || is_store) ? eff_addr : 32'd0;
    assign ram_out  = st_data;
    // Qualify memory strobes with reset so a store at word 0 cannot fire during reset.
    assign ram_r    = rst_n && is_load;
    assign ram_w    = (rst_n && !brk_q) ? st_mask : 4'b0000;
    assign brk      = brk_q;

endmodule

// File: tb/tb_rv32i_core.sv
// Directed testbench for rv32i_core: small programs in a bench-side ROM, a byte-lane RAM model,
// and hand-computed expectations checked with immediate assertions.
module tb_rv32i_core;

    localparam logic [6:0] OPI   = 7'h13;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] JALR  = 7'h67;
    localparam logic [6:0] LD    = 7'h03;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_in, ram_in, ram_addr, ram_out;
    logic [29:0] rom_addr;
    logic        ram_r, brk;
    logic [3:0]  ram_w;

    logic [31:0] rom [64];
    logic [31:0] ram [256];

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    logic [31:0] pc_seq [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h04, 32'h08, 32'h0C,
                                 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h14};

    always #5 clk = ~clk;

    rv32i_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rom_in   (rom_in),
        .rom_addr (rom_addr),
        .ram_in   (ram_in),
        .ram_addr (ram_addr),
        .ram_out  (ram_out),
        .ram_r    (ram_r),
        .ram_w    (ram_w),
        .brk      (brk)
    );

    assign rom_in = (rom_addr < 30'd64) ? rom[rom_addr[5:0]] : NOP;
    assign ram_in = ram[ram_addr[9:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_w[i]) ram[ram_addr[9:2]][8*i +: 8] <= ram_out[8*i +: 8];
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) rom[i] = NOP;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // ---------------- Program 1: ALU shifts/compares, EBREAK at word 5 ----------------
        rst_n = 1'b0;
        clear_mem();
        rom[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI);  // ADDI x1,x0,-1
        rom[1] = enc_i(12'h01C, 5'd1, 3'd5, 5'd2, OPI);  // SRLI x2,x1,28
        rom[2] = enc_i(12'h41C, 5'd1, 3'd5, 5'd3, OPI);  // SRAI x3,x1,28
        rom[3] = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4);   // SLTU x4,x0,x1
        rom[4] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI);    // ADDI x0,x0,5
        rom[5] = EBREAK;
        #3;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_ram_w", 32'(ram_w), 32'd0);
        chk("rst_ram_r", 32'(ram_r), 32'd0);
        chk("rst_brk", 32'(brk), 32'd0);
        chk("rst_x2", dut.rf_q[2], 32'd0);
        release_reset();
        chk("p1_first_fetch", 32'(rom_addr), 32'd0);
        chk("p1_nonmem_ram_w", 32'(ram_w), 32'd0);
        chk("p1_nonmem_ram_addr", ram_addr, 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("p1_brk_before", 32'(brk), 32'd0);
        chk("p1_at_ebreak", 32'(rom_addr), 32'd5);
        step();
        chk("p1_brk_6th_edge", 32'(brk), 32'd1);
        chk("p1_x1", dut.rf_q[1], 32'hFFFF_FFFF);
        chk("p1_x2", dut.rf_q[2], 32'h0000_000F);
        chk("p1_x3", dut.rf_q[3], 32'hFFFF_FFFF);
        chk("p1_x4", dut.rf_q[4], 32'h0000_0001);
        chk("p1_x0", dut.rf_q[0], 32'h0);
        step();
        step();
        chk("p1_pc_hold", 32'(rom_addr), 32'd5);
        chk("p1_brk_sticky", 32'(brk), 32'd1);
        chk("p1_x2_hold", dut.rf_q[2], 32'h0000_000F);
        chk("p1_x4_hold", dut.rf_q[4], 32'h0000_0001);

        // Reset while halted, then reset mid-run; both must clear without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("rst_halt_brk", 32'(brk), 32'd0);
        chk("rst_halt_pc", dut.pc_q, 32'd0);
        chk("rst_halt_x2", dut.rf_q[2], 32'd0);
        release_reset();
        step();
        step();
        step();
        chk("mid_x2_before", dut.rf_q[2], 32'h0000_000F);
        chk("mid_pc_before", dut.pc_q, 32'h0000_000C);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", dut.pc_q, 32'd0);
        chk("mid_rst_x2", dut.rf_q[2], 32'd0);
        chk("mid_rst_brk", 32'(brk), 32'd0);
        release_reset();
        step();
        chk("mid_restart_pc", dut.pc_q, 32'h4);
        chk("mid_restart_x1", dut.rf_q[1], 32'hFFFF_FFFF);

        // ---------------- Program 2: loads and stores ----------------
        rst_n = 1'b0;
        clear_mem();
        ram[64] = 32'h8000_1234;                              // byte address 0x100
        rom[0]  = enc_i(12'h100, 5'd0, 3'd0, 5'd7, OPI);      // ADDI x7,x0,0x100
        rom[1]  = enc_i(12'd2, 5'd7, 3'd1, 5'd11, LD);        // LH  x11,2(x7)
        rom[2]  = enc_i(12'd2, 5'd7, 3'd5, 5'd12, LD);        // LHU x12,2(x7)
        rom[3]  = enc_u(20'h12345, 5'd5, LUI);                // LUI x5,0x12345
        rom[4]  = enc_i(12'h678, 5'd5, 3'd0, 5'd5, OPI);      // ADDI x5,x5,0x678
        rom[5]  = enc_i(12'h0AB, 5'd0, 3'd0, 5'd6, OPI);      // ADDI x6,x0,0xAB
        rom[6]  = enc_s(12'd0, 5'd5, 5'd7, 3'd2);             // SW x5,0(x7)
        rom[7]  = enc_s(12'd1, 5'd6, 5'd7, 3'd0);             // SB x6,1(x7)
        rom[8]  = enc_i(12'd0, 5'd7, 3'd2, 5'd8, LD);         // LW  x8,0(x7)
        rom[9]  = enc_i(12'd1, 5'd7, 3'd0, 5'd9, LD);         // LB  x9,1(x7)
        rom[10] = enc_i(12'd1, 5'd7, 3'd4, 5'd10, LD);        // LBU x10,1(x7)
        rom[11] = enc_s(12'd2, 5'd6, 5'd7, 3'd1);             // SH x6,2(x7)
        rom[12] = EBREAK;
        #1;
        release_reset();
        chk("p2_addi_ram_r", 32'(ram_r), 32'd0);
        step();
        chk("p2_lh_ram_r", 32'(ram_r), 32'd1);
        chk("p2_lh_addr", ram_addr, 32'h102);
        step();
        chk("p2_lh", dut.rf_q[11], 32'hFFFF_8000);
        step();
        chk("p2_lhu", dut.rf_q[12], 32'h0000_8000);
        step();
        step();
        step();
        chk("p2_x5", dut.rf_q[5], 32'h1234_5678);
        chk("p2_sw_ram_w", 32'(ram_w), 32'hF);
        chk("p2_sw_ram_out", ram_out, 32'h1234_5678);
        chk("p2_sw_addr", ram_addr, 32'h100);
        chk("p2_sw_ram_r", 32'(ram_r), 32'd0);
        step();
        chk("p2_sw_mem", ram[64], 32'h1234_5678);
        chk("p2_sb_ram_w", 32'(ram_w), 32'h2);
        chk("p2_sb_ram_out", ram_out, 32'hABAB_ABAB);
        chk("p2_sb_addr", ram_addr, 32'h101);
        step();
        step();
        chk("p2_lw", dut.rf_q[8], 32'h1234_AB78);
        step();
        chk("p2_lb", dut.rf_q[9], 32'hFFFF_FFAB);
        step();
        chk("p2_lbu", dut.rf_q[10], 32'h0000_00AB);
        chk("p2_sh_ram_w", 32'(ram_w), 32'hC);
        chk("p2_sh_ram_out", ram_out, 32'h00AB_00AB);
        step();
        chk("p2_sh_mem", ram[64], 32'h00AB_AB78);
        step();
        chk("p2_brk", 32'(brk), 32'd1);
        chk("p2_halt_ram_w", 32'(ram_w), 32'd0);

        // ---------------- Program 3: BNE loop, JAL, JALR ----------------
        rst_n = 1'b0;
        clear_mem();
        rom[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd1, OPI);         // ADDI x1,x0,3
        rom[1] = enc_i(12'd1, 5'd3, 3'd0, 5'd3, OPI);         // ADDI x3,x3,1
        rom[2] = enc_i(12'hFFF, 5'd1, 3'd0, 5'd1, OPI);       // ADDI x1,x1,-1
        rom[3] = enc_b(13'h1FF8, 5'd0, 5'd1, 3'd1);           // BNE x1,x0,-8
        rom[4] = enc_j(21'd8, 5'd1);                          // JAL x1,+8
        rom[5] = EBREAK;
        rom[6] = enc_i(12'd1, 5'd1, 3'd0, 5'd0, JALR);        // JALR x0,x1,1
        #1;
        release_reset();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("p3_pc_%0d", i), dut.pc_q, pc_seq[i]);
            if (i == 11) chk("p3_jal_link", dut.rf_q[1], 32'h14);
            step();
        end
        chk("p3_loop_count", dut.rf_q[3], 32'd3);
        chk("p3_brk", 32'(brk), 32'd1);
        chk("p3_halt_pc", dut.pc_q, 32'h14);

        // ---------------- Program 4: mixed ALU ops and branch types ----------------
        rst_n = 1'b0;
        clear_mem();
        rom[0]  = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OPI);      // ADDI x1,x0,-5
        rom[1]  = enc_i(12'd3, 5'd0, 3'd0, 5'd2, OPI);        // ADDI x2,x0,3
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3);       // SLT  x3,x1,x2
        rom[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4);       // SLTU x4,x1,x2
        rom[4]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd5);       // SUB  x5,x2,x1
        rom[5]  = enc_i(12'hFFF, 5'd2, 3'd3, 5'd6, OPI);      // SLTIU x6,x2,-1
        rom[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd7);       // XOR  x7,x1,x2
        rom[7]  = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd8);       // SRA  x8,x1,x2
        rom[8]  = enc_r(7'h00, 5'd2, 5'd2, 3'd1, 5'd9);       // SLL  x9,x2,x2
        rom[9]  = enc_b(13'd8, 5'd2, 5'd1, 3'd4);             // BLT  x1,x2,+8 (taken)
        rom[10] = enc_i(12'd1, 5'd0, 3'd0, 5'd10, OPI);
        rom[11] = enc_b(13'd8, 5'd2, 5'd1, 3'd7);             // BGEU x1,x2,+8 (taken)
        rom[12] = enc_i(12'd2, 5'd10, 3'd0, 5'd10, OPI);
        rom[13] = enc_b(13'd8, 5'd2, 5'd1, 3'd5);             // BGE  x1,x2,+8 (not taken)
        rom[14] = enc_i(12'd7, 5'd0, 3'd0, 5'd11, OPI);       // ADDI x11,x0,7
        rom[15] = enc_u(20'h00001, 5'd12, AUIPC);             // AUIPC x12,1
        rom[16] = enc_i(12'h0F0, 5'd1, 3'd7, 5'd13, OPI);     // ANDI x13,x1,0xF0
        rom[17] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);             // BEQ  x0,x0,+8 (taken)
        rom[18] = enc_i(12'd4, 5'd10, 3'd0, 5'd10, OPI);
        rom[19] = enc_b(13'd8, 5'd1, 5'd2, 3'd6);             // BLTU x2,x1,+8 (taken)
        rom[20] = enc_i(12'd8, 5'd10, 3'd0, 5'd10, OPI);
        rom[21] = 32'h0000_0073;                              // ECALL as NOP
        rom[22] = EBREAK;
        #1;
        release_reset();
        cyc = 0;
        while (!brk && cyc < 60) begin
            step();
            cyc++;
        end
        chk("p4_cycles", 32'(cyc), 32'd19);
        chk("p4_slt", dut.rf_q[3], 32'd1);
        chk("p4_sltu", dut.rf_q[4], 32'd0);
        chk("p4_sub", dut.rf_q[5], 32'd8);
        chk("p4_sltiu", dut.rf_q[6], 32'd1);
        chk("p4_xor", dut.rf_q[7], 32'hFFFF_FFF8);
        chk("p4_sra", dut.rf_q[8], 32'hFFFF_FFFF);
        chk("p4_sll", dut.rf_q[9], 32'h18);
        chk("p4_skipped", dut.rf_q[10], 32'd0);
        chk("p4_fallthru", dut.rf_q[11], 32'd7);
        chk("p4_auipc", dut.rf_q[12], 32'h103C);
        chk("p4_andi", dut.rf_q[13], 32'hF0);
        chk("p4_halt_pc", dut.pc_q, 32'h58);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
